// File: rtl/camera_sensor_emulator_if.sv
// Parallel sensor-style video bus between the emulator and a capture block.
// Source-synchronous stream: no ready/backpressure; the consumer must accept every cycle where line_valid=1.
interface camera_sensor_emulator_if;
    logic        en;
    logic [1:0]  pattern;
    logic        frame_valid;
    logic        line_valid;
    logic [9:0]  data_out;
    logic [15:0] frame_count;
    logic        frame_end;
    logic [2:0]  dbg_state;

    modport master (
        input  en, pattern,
        output frame_valid, line_valid, data_out, frame_count, frame_end, dbg_state
    );

    modport slave (
        output en, pattern,
        input  frame_valid, line_valid, data_out, frame_count, frame_end, dbg_state
    );
endinterface

// File: rtl/camera_sensor_emulator.sv
// MT9V034-style parallel output generator: frame/line timing with blanking and selectable test patterns.
// All bus outputs are registered from the next-state values, so DATA stays aligned with LINE_VALID.
module camera_sensor_emulator #(
    parameter int H  = 752,
    parameter int V  = 480,
    parameter int HB = 94,
    parameter int P1 = 2,
    parameter int P2 = 2,
    parameter int VB = 45
) (
    input  logic                            clk,
    input  logic                            rst,
    camera_sensor_emulator_if.master        bus
);
    localparam int CW    = (H > 1) ? $clog2(H) : 1;
    localparam int LW    = (V > 1) ? $clog2(V) : 1;
    localparam int MAX_A = (HB > P1) ? HB : P1;
    localparam int MAX_B = (P2 > VB) ? P2 : VB;
    localparam int MAXB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int BW    = $clog2(MAXB + 1);

    localparam logic [CW-1:0] COL_LAST  = CW'(H - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V - 1);
    localparam logic [BW-1:0] HB_LAST   = BW'(HB - 1);
    localparam logic [BW-1:0] P1_LAST   = BW'(P1 - 1);
    localparam logic [BW-1:0] P2_LAST   = BW'(P2 - 1);
    localparam logic [BW-1:0] VB_LAST   = BW'(VB - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FSTART = 3'd1,
        ACTIVE = 3'd2,
        HBLANK = 3'd3,
        FEND   = 3'd4,
        VBLANK = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] blank_cnt, blank_n;
    logic [CW-1:0] col, col_n;
    logic [LW-1:0] line, line_n;
    logic [1:0]    pat, pat_n;
    logic [15:0]   fc_n;
    logic          fe_n, fv_n, lv_n;
    logic [9:0]    data_n;
    logic [9:0]    c10, l10, diag10;

    assign bus.dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            blank_cnt       <= '0;
            col             <= '0;
            line            <= '0;
            pat             <= '0;
            bus.frame_valid <= 1'b0;
            bus.line_valid  <= 1'b0;
            bus.data_out    <= '0;
            bus.frame_count <= '0;
            bus.frame_end   <= 1'b0;
        end else begin
            state           <= state_n;
            blank_cnt       <= blank_n;
            col             <= col_n;
            line            <= line_n;
            pat             <= pat_n;
            bus.frame_valid <= fv_n;
            bus.line_valid  <= lv_n;
            bus.data_out    <= data_n;
            bus.frame_count <= fc_n;
            bus.frame_end   <= fe_n;
        end
    end

    // blank_cnt counts cycles spent in the current blanking state; each state exits on its LAST value.
    always_comb begin
        state_n = state;
        blank_n = blank_cnt;
        col_n   = col;
        line_n  = line;
        pat_n   = pat;
        fc_n    = bus.frame_count;
        fe_n    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_n = FSTART;
                    blank_n = '0;
                    pat_n   = bus.pattern;
                end
            end
            FSTART: begin
                if (blank_cnt == P1_LAST) begin
                    state_n = ACTIVE;
                    blank_n = '0;
                    col_n   = '0;
                    line_n  = '0;
                end else begin
                    blank_n = blank_cnt + BW'(1);
                end
            end
            ACTIVE: begin
                if (col == COL_LAST) begin
                    col_n   = '0;
                    blank_n = '0;
                    state_n = (line == LINE_LAST) ? FEND : HBLANK;
                end else begin
                    col_n = col + CW'(1);
                end
            end
            HBLANK: begin
                if (blank_cnt == HB_LAST) begin
                    state_n = ACTIVE;
                    blank_n = '0;
                    col_n   = '0;
                    line_n  = line + LW'(1);
                end else begin
                    blank_n = blank_cnt + BW'(1);
                end
            end
            FEND: begin
                if (blank_cnt == P2_LAST) begin
                    state_n = VBLANK;
                    blank_n = '0;
                    fe_n    = 1'b1;
                    fc_n    = bus.frame_count + 16'd1;
                end else begin
                    blank_n = blank_cnt + BW'(1);
                end
            end
            VBLANK: begin
                if (blank_cnt == VB_LAST) begin
                    blank_n = '0;
                    if (bus.en) begin
                        state_n = FSTART;
                        pat_n   = bus.pattern;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    blank_n = blank_cnt + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                blank_n = '0;
            end
        endcase
    end

    // Pixel value for the coming cycle, computed from the next column/line so it lands with LINE_VALID.
    always_comb begin
        c10    = 10'(col_n);
        l10    = 10'(line_n);
        diag10 = c10 + l10 + 10'(bus.frame_count);
        fv_n   = (state_n == FSTART) || (state_n == ACTIVE) ||
                 (state_n == HBLANK) || (state_n == FEND);
        lv_n   = (state_n == ACTIVE);
        data_n = '0;
        if (lv_n) begin
            case (pat)
                2'd0:    data_n = c10;
                2'd1:    data_n = l10;
                2'd2:    data_n = (c10[3] ^ l10[3]) ? 10'h3FF : 10'h000;
                default: data_n = diag10;
            endcase
        end
    end
endmodule
